// File: rtl/fm_stream_tx.sv
// fm_stream_tx
//
// Feature-map stream transmitter. It reads one FM_WIDTH x FM_WIDTH frame of
// FM_DEPTH-channel pixels from the frame memory in raster order and replays it
// on the layer-input stream. The frame starts with a verticle_sync pulse. Pixels
// follow, one strobe every PERIOD cycles, and downstream can pause issue with
// hold.
//
// Ports:
//   clk            clock, all logic on posedge
//   rst            asynchronous active-high reset
//   start          one-cycle frame request, ignored while busy
//   hold           pauses pixel issue (downstream throttle)
//   mem_rd_en      memory read strobe
//   mem_addr       pixel index row*FM_WIDTH+col
//   mem_rd_data    read data, valid exactly one cycle after mem_rd_en
//   verticle_sync  one-cycle start-of-frame pulse
//   mode_out       wrapper mode, 1 = calculate, high from sync through done
//   data_out_valid one-cycle pixel strobe
//   data_out       pixel data, held between strobes
//   busy           frame in progress
//   frame_done     one-cycle pulse in the cycle after the last strobe
module fm_stream_tx #(
  parameter int FM_DEPTH = 64,
  parameter int FM_WIDTH = 56,
  parameter int PERIOD   = 8,
  parameter int VS_GAP   = 4,
  parameter int AW       = $clog2(FM_WIDTH*FM_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  hold,
  output logic                  mem_rd_en,
  output logic [AW-1:0]         mem_addr,
  input  logic [16*FM_DEPTH-1:0] mem_rd_data,
  output logic                  verticle_sync,
  output logic                  mode_out,
  output logic                  data_out_valid,
  output logic [16*FM_DEPTH-1:0] data_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int NPIX = FM_WIDTH * FM_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    GAP,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [7:0]    phase;
  logic [7:0]    gap_cnt;
  // One spare bit so the index can step past the last pixel without wrapping.
  logic [AW:0]   pix_idx;
  logic          rd_pending;
  logic          issue;
  logic          last_issue;

  // A read goes out on the phase-0 cycle of STREAM unless downstream is
  // holding in that same cycle. This is why the read strobe is decoded from
  // the current state and hold rather than registered: a hold seen at phase 0
  // has to suppress the read in that very cycle.
  always_comb begin
    issue      = (state == STREAM) && (phase == 8'd0) && !hold;
    last_issue = issue && (pix_idx == (AW+1)'(NPIX - 1));
  end

  assign mem_rd_en = issue;
  assign mem_addr  = pix_idx[AW-1:0];

  // Frame sequencing. DRAIN leaves on the strobe of the final pixel, so
  // DONE always falls in the cycle right after the last strobe.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SYNC;
      SYNC:    next_state = GAP;
      GAP:     if (gap_cnt == 8'(VS_GAP - 1)) next_state = STREAM;
      STREAM:  if (last_issue) next_state = DRAIN;
      DRAIN:   if (data_out_valid) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Gap and pixel cadence counters. The phase counter and pixel index both
  // freeze for every cycle of hold in STREAM. Each held cycle therefore pushes
  // all later strobes back by exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= 8'd0;
      gap_cnt <= 8'd0;
      pix_idx <= '0;
    end else begin
      case (state)
        SYNC: begin
          phase   <= 8'd0;
          gap_cnt <= 8'd0;
          pix_idx <= '0;
        end
        GAP: begin
          gap_cnt <= gap_cnt + 8'd1;
        end
        STREAM: begin
          if (!hold) begin
            phase <= (phase == 8'(PERIOD - 1)) ? 8'd0 : phase + 8'd1;
          end
          if (issue) begin
            pix_idx <= pix_idx + (AW+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered frame-level outputs, taken from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      verticle_sync <= 1'b0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
      mode_out      <= 1'b0;
    end else begin
      verticle_sync <= (next_state == SYNC);
      frame_done    <= (next_state == DONE);
      busy          <= (next_state != IDLE);
      mode_out      <= (next_state != IDLE);
    end
  end

  // Read return path. Memory data is captured in the cycle it is valid, and
  // the strobe follows one cycle later. A read that has been issued always
  // completes, whatever hold does. Reset drops any read still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending     <= 1'b0;
      data_out_valid <= 1'b0;
      data_out       <= '0;
    end else begin
      rd_pending     <= issue;
      data_out_valid <= rd_pending;
      if (rd_pending) begin
        data_out <= mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_fm_stream_tx.sv
// tb_fm_stream_tx
//
// Two instances are used: A (PERIOD=8, VS_GAP=4) and B (PERIOD=3, VS_GAP=1).
// Both have a 4x4 frame of 4 channels, and sel picks which one is active.
// Memory word[ch] = addr*256+ch. Outside the valid read-return cycle the
// memory drives random junk. The reference model treats reads as happening on
// every PERIOD-th un-held streaming cycle, beginning 2+VS_GAP cycles after
// start. Each strobe follows its read 2 cycles later, and done comes 3 cycles
// after the last read.
module tb_fm_stream_tx;

  localparam int D  = 4;
  localparam int W  = 4;
  localparam int N  = W * W;
  localparam int DW = 16 * D;
  localparam int AB = $clog2(N);

  typedef struct {
    int at;
    int pix;
  } strobe_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic hold = 1'b0;
  logic sel = 1'b0;
  int   cyc = 0;
  int   cur_period = 8;
  int   cur_gap = 4;

  logic          start_a, hold_a, rd_en_a, vs_a, mode_a, val_a, busy_a, done_a;
  logic [AB-1:0] addr_a;
  logic [DW-1:0] rdd_a, dout_a;
  logic          start_b, hold_b, rd_en_b, vs_b, mode_b, val_b, busy_b, done_b;
  logic [AB-1:0] addr_b;
  logic [DW-1:0] rdd_b, dout_b;

  logic          o_rd_en, o_vs, o_mode, o_val, o_busy, o_done;
  logic [AB-1:0] o_addr;
  logic [DW-1:0] o_dout;

  strobe_t       str_q[$];
  int            vs_q[$];
  int            done_q[$];
  logic [DW-1:0] exp_data = '0;
  bit            idle_next = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;

  assign start_a = start && !sel;
  assign hold_a  = hold && !sel;
  assign start_b = start && sel;
  assign hold_b  = hold && sel;

  assign o_rd_en = sel ? rd_en_b : rd_en_a;
  assign o_addr  = sel ? addr_b  : addr_a;
  assign o_vs    = sel ? vs_b    : vs_a;
  assign o_mode  = sel ? mode_b  : mode_a;
  assign o_val   = sel ? val_b   : val_a;
  assign o_dout  = sel ? dout_b  : dout_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_done  = sel ? done_b  : done_a;

  fm_stream_tx #(.FM_DEPTH(D), .FM_WIDTH(W), .PERIOD(8), .VS_GAP(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .hold(hold_a),
    .mem_rd_en(rd_en_a), .mem_addr(addr_a), .mem_rd_data(rdd_a),
    .verticle_sync(vs_a), .mode_out(mode_a), .data_out_valid(val_a),
    .data_out(dout_a), .busy(busy_a), .frame_done(done_a)
  );

  fm_stream_tx #(.FM_DEPTH(D), .FM_WIDTH(W), .PERIOD(3), .VS_GAP(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .hold(hold_b),
    .mem_rd_en(rd_en_b), .mem_addr(addr_b), .mem_rd_data(rdd_b),
    .verticle_sync(vs_b), .mode_out(mode_b), .data_out_valid(val_b),
    .data_out(dout_b), .busy(busy_b), .frame_done(done_b)
  );

  function automatic logic [DW-1:0] pixelWord(input int pix);
    logic [DW-1:0] w;
    w = '0;
    for (int ch = 0; ch < D; ch++) w[ch*16 +: 16] = 16'(pix * 256 + ch);
    return w;
  endfunction

  function automatic logic [DW-1:0] junkWord();
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  always #5 clk = ~clk;

  // Cycle counter: cycle k starts at the k-th posedge.
  always @(posedge clk) cyc++;

  // Frame memories with one-cycle read latency; junk whenever no read is returning.
  always @(posedge clk) begin
    rdd_a <= rd_en_a ? pixelWord(int'(addr_a)) : junkWord();
    rdd_b <= rd_en_b ? pixelWord(int'(addr_b)) : junkWord();
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkAllZero();
    checkOutput("rst_rd_en", DW'(o_rd_en), '0);
    checkOutput("rst_addr",  DW'(o_addr),  '0);
    checkOutput("rst_vsync", DW'(o_vs),    '0);
    checkOutput("rst_mode",  DW'(o_mode),  '0);
    checkOutput("rst_valid", DW'(o_val),   '0);
    checkOutput("rst_data",  o_dout,       '0);
    checkOutput("rst_busy",  DW'(o_busy),  '0);
    checkOutput("rst_done",  DW'(o_done),  '0);
  endtask

  task automatic flushModel();
    str_q.delete();
    vs_q.delete();
    done_q.delete();
    exp_data  = '0;
    idle_next = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    hold = 1'b0;
    flushModel();
    #1;
    checkAllZero();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one frame from the next negedge and pushes the expected events.
  // The hold in each cycle is random with probability hold_pct, plus a fixed
  // window [hold_from, hold_from+hold_len). Extra start pulses can be placed
  // at the offsets busy_s1/busy_s2. If reset_at>0, reset is asserted at that
  // offset. The task returns on the negedge of the cycle after frame_done, or
  // after the reset.
  task automatic applyStimulus(input int hold_pct, input int hold_from, input int hold_len,
                               input int busy_s1, input int busy_s2, input int reset_at,
                               output int done_cyc);
    int c0, c, nonheld, reads, last_read;
    bit h;
    @(negedge clk);
    c0 = cyc;
    c = c0;
    nonheld = 0;
    reads = 0;
    last_read = -1;
    done_cyc = -1;
    vs_q.push_back(c0 + 1);
    forever begin
      start = (c == c0) || (busy_s1 > 0 && c - c0 == busy_s1) || (busy_s2 > 0 && c - c0 == busy_s2);
      if (reset_at > 0 && c - c0 == reset_at) begin
        rst = 1'b1;
        start = 1'b0;
        hold = 1'b0;
        flushModel();
        #1;
        checkAllZero();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      h = ($urandom_range(99) < hold_pct) || (c - c0 >= hold_from && c - c0 < hold_from + hold_len);
      hold = h;
      if (reads < N && c >= c0 + 2 + cur_gap && !h) begin
        nonheld++;
        if ((nonheld - 1) % cur_period == 0) begin
          str_q.push_back('{c + 2, reads});
          reads++;
          if (reads == N) begin
            last_read = c;
            done_q.push_back(c + 3);
          end
        end
      end
      if (last_read >= 0 && c == last_read + 3) begin
        done_cyc = c;
        @(negedge clk);
        start = 1'b0;
        hold = 1'b0;
        return;
      end
      @(negedge clk);
      c = cyc;
    end
  endtask

  // Monitor: samples 1 time unit after each posedge and compares every event against the queues.
  initial begin
    strobe_t s;
    forever begin
      @(posedge clk);
      #1;
      if (idle_next) begin
        checkOutput("busy_after_done", DW'(o_busy), '0);
        checkOutput("mode_after_done", DW'(o_mode), '0);
        idle_next = 1'b0;
      end
      if (o_vs) begin
        if (vs_q.size() == 0) begin
          checkOutput("vsync_extra", DW'(o_vs), '0);
        end else begin
          checkOutput("vsync_cycle", DW'(cyc), DW'(vs_q.pop_front()));
          checkOutput("vsync_busy", DW'(o_busy), DW'(1));
          checkOutput("vsync_mode", DW'(o_mode), DW'(1));
        end
      end
      if (o_val) begin
        if (str_q.size() == 0) begin
          checkOutput("strobe_extra", DW'(o_val), '0);
        end else begin
          s = str_q.pop_front();
          exp_data = pixelWord(s.pix);
          checkOutput("strobe_cycle", DW'(cyc), DW'(s.at));
          checkOutput("strobe_data", o_dout, exp_data);
          checkOutput("strobe_mode", DW'(o_mode), DW'(1));
        end
      end else begin
        checkOutput("data_hold", o_dout, exp_data);
      end
      if (o_done) begin
        if (done_q.size() == 0) begin
          checkOutput("done_extra", DW'(o_done), '0);
        end else begin
          checkOutput("done_cycle", DW'(cyc), DW'(done_q.pop_front()));
          checkOutput("done_busy", DW'(o_busy), DW'(1));
          idle_next = 1'b1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, expected end earlier", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkAllZero();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal frame, with start pulses at 20 (streaming) and 129 (DONE) that must be ignored.
    applyStimulus(0, 0, 0, 20, 129, 0, d);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    // Five-cycle hold starting on pixel 3's phase-0 cycle.
    applyStimulus(0, 30, 5, 0, 0, 0, d);
    // Hold raised the cycle after pixel 5's read.
    applyStimulus(0, 47, 4, 0, 0, 0, d);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    // Random throttling.
    applyStimulus(25, 0, 0, 0, 0, 0, d);
    // Reset in the middle of a frame, then restart from pixel 0.
    applyStimulus(15, 0, 0, 0, 0, 50, d);
    repeat (2) @(negedge clk);
    applyStimulus(10, 0, 0, 0, 0, 0, d);

    // Back-to-back frames on the short-period instance.
    applyReset();
    sel = 1'b1;
    cur_period = 3;
    cur_gap = 1;
    repeat (2) @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, d);
    applyStimulus(20, 0, 0, 0, 0, 0, d);
    applyStimulus(0, 0, 0, 0, 0, 0, d);

    repeat (8) @(negedge clk);
    checkOutput("strobes_left", DW'(str_q.size()), '0);
    checkOutput("vsyncs_left", DW'(vs_q.size()), '0);
    checkOutput("dones_left", DW'(done_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
